// File: rtl/decode_stage.sv
// decode_stage: ID stage of the 5-stage MIPS pipeline.
// Holds the IF/ID register (stall/flush), the 32x32 register file with
// write-through bypass, sign extension, and early branch/jump resolution.
// Ports:
//   CLK, RST                 clock, async active-low reset
//   StallD, FlushD           IF/ID hold / clear-to-bubble (flush wins)
//   InstrF, PCPlus4F         fetch-stage instruction and PC+4
//   RegWriteW/WriteRegW/ResultW  writeback port
//   ForwardAD/ForwardBD/ALUOutM  comparator operand forwarding from MEM
//   InstrD, PCPlus4D         registered fetch values
//   RD1D, RD2D               rs/rt read data
//   SignImmD, RsD, RtD, RdD  decoded fields
//   PCBranchD, PCJumpD       branch and jump targets
//   BranchTakenD, JumpD      control-flow redirect indications
module decode_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter logic [5:0]  OP_BEQ    = 6'b000100,
   parameter logic [5:0]  OP_BNE    = 6'b000101,
   parameter logic [5:0]  OP_J      = 6'b000010
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic [31:0] InstrF,
   input  logic [31:0] PCPlus4F,
   input  logic        RegWriteW,
   input  logic [4:0]  WriteRegW,
   input  logic [31:0] ResultW,
   input  logic        ForwardAD,
   input  logic        ForwardBD,
   input  logic [31:0] ALUOutM,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic [31:0] RD1D,
   output logic [31:0] RD2D,
   output logic [31:0] SignImmD,
   output logic [4:0]  RsD,
   output logic [4:0]  RtD,
   output logic [4:0]  RdD,
   output logic [31:0] PCBranchD,
   output logic [31:0] PCJumpD,
   output logic        BranchTakenD,
   output logic        JumpD
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   ifid_t       ifid;
   logic [31:0] rf [32];
   logic        wr_en;
   logic [5:0]  op;
   logic [31:0] cmp_a, cmp_b;
   logic        eq;

   // IF/ID register: flush beats stall
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ifid.instr <= NOP_INSTR;
         ifid.pc4   <= '0;
      end else if (FlushD) begin
         ifid.instr <= NOP_INSTR;
         ifid.pc4   <= '0;
      end else if (!StallD) begin
         ifid.instr <= InstrF;
         ifid.pc4   <= PCPlus4F;
      end
   end

   assign InstrD   = ifid.instr;
   assign PCPlus4D = ifid.pc4;

   // register file; entry 0 is never written and is masked on read
   assign wr_en = RegWriteW && (WriteRegW != 5'd0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wr_en) begin
         rf[WriteRegW] <= ResultW;
      end
   end

   assign op       = InstrD[31:26];
   assign RsD      = InstrD[25:21];
   assign RtD      = InstrD[20:16];
   assign RdD      = InstrD[15:11];
   assign SignImmD = {{16{InstrD[15]}}, InstrD[15:0]};

   // write-through bypass lets a same-cycle writeback reach decode without a stall
   always_comb begin
      RD1D = (RsD == 5'd0) ? 32'd0 : rf[RsD];
      RD2D = (RtD == 5'd0) ? 32'd0 : rf[RtD];
      if (wr_en && (WriteRegW == RsD)) RD1D = ResultW;
      if (wr_en && (WriteRegW == RtD)) RD2D = ResultW;
   end

   assign PCBranchD = PCPlus4D + {SignImmD[29:0], 2'b00};
   assign PCJumpD   = {PCPlus4D[31:28], InstrD[25:0], 2'b00};

   assign cmp_a = ForwardAD ? ALUOutM : RD1D;
   assign cmp_b = ForwardBD ? ALUOutM : RD2D;
   assign eq    = (cmp_a == cmp_b);

   assign BranchTakenD = ((op == OP_BEQ) && eq) || ((op == OP_BNE) && !eq);
   assign JumpD        = (op == OP_J);

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Expectations are queued
// alongside the stimulus and drained against the DUT outputs mid-cycle.
module tb_decode_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        StallD, FlushD;
   logic [31:0] InstrF, PCPlus4F;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic        ForwardAD, ForwardBD;
   logic [31:0] ALUOutM;
   logic [31:0] InstrD, PCPlus4D, RD1D, RD2D, SignImmD, PCBranchD, PCJumpD;
   logic [4:0]  RsD, RtD, RdD;
   logic        BranchTakenD, JumpD;

   decode_stage dut (
      .CLK(CLK), .RST(RST), .StallD(StallD), .FlushD(FlushD),
      .InstrF(InstrF), .PCPlus4F(PCPlus4F),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM),
      .InstrD(InstrD), .PCPlus4D(PCPlus4D), .RD1D(RD1D), .RD2D(RD2D),
      .SignImmD(SignImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
      .BranchTakenD(BranchTakenD), .JumpD(JumpD)
   );

   always #5 CLK = ~CLK;

   typedef enum int {S_INSTR, S_PC4, S_RD1, S_RD2, S_IMM, S_RS, S_RT, S_RD,
                     S_PCB, S_PCJ, S_BT, S_JMP} sel_t;
   typedef struct {
      string       tag;
      sel_t        sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %08h want %08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] obs(input sel_t s);
      case (s)
         S_INSTR: return InstrD;
         S_PC4:   return PCPlus4D;
         S_RD1:   return RD1D;
         S_RD2:   return RD2D;
         S_IMM:   return SignImmD;
         S_RS:    return {27'd0, RsD};
         S_RT:    return {27'd0, RtD};
         S_RD:    return {27'd0, RdD};
         S_PCB:   return PCBranchD;
         S_PCJ:   return PCJumpD;
         S_BT:    return {31'd0, BranchTakenD};
         default: return {31'd0, JumpD};
      endcase
   endfunction

   task automatic ex(input string tag, input sel_t s, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.sel = s; e.val = v;
      sb.push_back(e);
   endtask

   // let combinational outputs settle, then compare everything queued
   task automatic drain();
      exp_t e;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, obs(e.sel), e.val);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] d);
      RegWriteW = 1'b1; WriteRegW = r; ResultW = d;
      tick();
      RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0;
   endtask

   initial begin
      RST = 1'b1; StallD = 0; FlushD = 0; InstrF = '0; PCPlus4F = '0;
      RegWriteW = 0; WriteRegW = '0; ResultW = '0;
      ForwardAD = 0; ForwardBD = 0; ALUOutM = '0;
      #1 RST = 1'b0;

      // reset state
      ex("rst_instr", S_INSTR, 0); ex("rst_pc4", S_PC4, 0);
      ex("rst_rd1", S_RD1, 0);     ex("rst_rd2", S_RD2, 0);
      ex("rst_imm", S_IMM, 0);     ex("rst_pcb", S_PCB, 0);
      ex("rst_pcj", S_PCJ, 0);     ex("rst_bt", S_BT, 0);
      ex("rst_jmp", S_JMP, 0);     ex("rst_rs", S_RS, 0);
      drain();

      // addi $8,$0,5
      RST = 1'b1;
      InstrF = 32'h2008_0005; PCPlus4F = 32'h4;
      tick();
      ex("addi_instr", S_INSTR, 32'h2008_0005); ex("addi_pc4", S_PC4, 32'h4);
      ex("addi_imm", S_IMM, 32'h5); ex("addi_rs", S_RS, 0); ex("addi_rt", S_RT, 8);
      ex("addi_bt", S_BT, 0); ex("addi_jmp", S_JMP, 0);
      drain();

      // bypass to rs=9, then read from storage
      InstrF = 32'h0120_0000; tick();
      RegWriteW = 1; WriteRegW = 5'd9; ResultW = 32'hDEAD_BEEF;
      ex("byp_rd1", S_RD1, 32'hDEAD_BEEF);
      drain();
      tick();
      RegWriteW = 0; WriteRegW = '0; ResultW = '0;
      ex("stored_rd1", S_RD1, 32'hDEAD_BEEF);
      drain();
      // write to R0 is neither bypassed nor stored (rt=0 here)
      RegWriteW = 1; WriteRegW = 5'd0; ResultW = 32'h1234;
      ex("r0_byp", S_RD2, 0);
      drain();
      tick();
      RegWriteW = 0; ResultW = '0;
      ex("r0_stored", S_RD2, 0);
      drain();

      // beq/bne with R1=R2=7
      wr(5'd1, 32'd7); wr(5'd2, 32'd7);
      InstrF = 32'h1022_FFFF; PCPlus4F = 32'h100; tick();
      ex("beq_rd1", S_RD1, 7); ex("beq_rd2", S_RD2, 7);
      ex("beq_imm", S_IMM, 32'hFFFF_FFFF); ex("beq_pcb", S_PCB, 32'hFC);
      ex("beq_bt", S_BT, 1);
      drain();
      InstrF = 32'h1422_FFFF; tick();
      ex("bne_eq_bt", S_BT, 0);
      drain();

      // forwarding: R1=3, R2=5
      InstrF = 32'h1022_FFFF;
      wr(5'd1, 32'd3); wr(5'd2, 32'd5);
      ex("beq_ne_bt", S_BT, 0);
      drain();
      ForwardBD = 1; ALUOutM = 32'd3;
      ex("fwdB_bt", S_BT, 1);
      drain();
      ForwardBD = 0; ForwardAD = 1; ALUOutM = 32'd5;
      ex("fwdA_bt", S_BT, 1);
      drain();
      ForwardAD = 0; ALUOutM = '0;

      // branch target wrap: beq $0,$0,+1 at PC+4 = 0xFFFF_FFFC
      InstrF = 32'h1000_0001; PCPlus4F = 32'hFFFF_FFFC; tick();
      ex("wrap_pcb", S_PCB, 32'h0); ex("wrap_bt", S_BT, 1);
      drain();

      // unused opcode drives no control
      InstrF = 32'hFC00_0000; tick();
      ex("unused_bt", S_BT, 0); ex("unused_jmp", S_JMP, 0);
      drain();

      // stall holds, flush beats stall
      InstrF = 32'h2008_0005; PCPlus4F = 32'h8; tick();
      StallD = 1; InstrF = 32'h2009_0007; PCPlus4F = 32'hC; tick();
      ex("stall1_instr", S_INSTR, 32'h2008_0005); ex("stall1_pc4", S_PC4, 32'h8);
      drain();
      InstrF = 32'h200A_0009; PCPlus4F = 32'h10; tick();
      ex("stall2_instr", S_INSTR, 32'h2008_0005);
      drain();
      FlushD = 1; tick();
      ex("flush_instr", S_INSTR, 0); ex("flush_pc4", S_PC4, 0);
      ex("flush_bt", S_BT, 0); ex("flush_jmp", S_JMP, 0);
      drain();
      StallD = 0; FlushD = 0;

      // jump
      InstrF = 32'h0800_0010; PCPlus4F = 32'hA000_0004; tick();
      ex("j_jmp", S_JMP, 1); ex("j_pcj", S_PCJ, 32'hA000_0040); ex("j_bt", S_BT, 0);
      drain();

      // async reset mid-cycle, no edge in between
      RST = 1'b0;
      ex("arst_instr", S_INSTR, 0); ex("arst_pc4", S_PC4, 0);
      ex("arst_jmp", S_JMP, 0); ex("arst_pcj", S_PCJ, 0);
      drain();
      RST = 1'b1;
      // R1 held 3 before the reset; it must now read 0
      InstrF = 32'h0020_0000; PCPlus4F = 32'h4; tick();
      ex("arst_rf_r1", S_RD1, 0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
